// File: rtl/ppe_arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Optional hold timeout is enabled with PPE_ARB_HOLD_TIMEOUT_EN.
package ppe_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_HOLD_DEF = 1024;

    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/ppe_arb_param.sv
// Programmable priority encoder: lowest set req bit at or above ptr,
// wrapping to the lowest set bit overall when none is found.
module ppe_param #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [W-1:0]     mask;
    logic [W-1:0]     masked;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W-1:0] u_idx;
    logic             m_vld;
    logic             u_vld;

    // thermometer mask: bits at or above the pointer
    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (IDX_W'(i) >= ptr);
        end
    end

    assign masked = req & mask;

    // lowest set bit among the masked requests
    always_comb begin
        m_idx = '0;
        m_vld = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (masked[i]) begin
                m_idx = IDX_W'(i);
                m_vld = 1'b1;
            end
        end
    end

    // lowest set bit among all requests, used on wrap
    always_comb begin
        u_idx = '0;
        u_vld = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                u_idx = IDX_W'(i);
                u_vld = 1'b1;
            end
        end
    end

    assign idx   = m_vld ? m_idx : u_idx;
    assign valid = u_vld;

endmodule

// File: rtl/ppe_rr_arbiter.sv
// Round-robin arbiter with registered grant held until release/withdrawal.
// Define PPE_ARB_HOLD_TIMEOUT_EN to force-end grants after MAX_HOLD cycles.
module ppe_rr_arbiter
    import ppe_arb_pkg::*;
#(
    parameter int W        = 512,
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
    parameter int MAX_HOLD = MAX_HOLD_DEF,
`endif
    parameter int IDX_W    = idx_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     req,
    input  logic             rel,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [W-1:0]     grant_onehot,
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
    output logic             timeout_pulse,
`endif
    output logic [IDX_W-1:0] rr_ptr
);

    arb_state_t       state;
    arb_state_t       state_n;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] gidx_n;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_n;
    logic [W-1:0]     oh;
    logic [W-1:0]     oh_n;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_vld;
    logic             force_end;
    logic             grant_end;

    ppe_param #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_ppe (
        .req   (req),
        .ptr   (ptr),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

`ifdef PPE_ARB_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             tp;
    logic             tp_n;

    assign force_end = (state == GRANT) &&
                       (cnt == CNT_W'(MAX_HOLD - 1));
    // pulse only when the timeout alone ended the grant
    assign tp_n = force_end && !rel && req[gidx];

    // hold counter: cleared at grant start, counts grant cycles
    always_comb begin
        cnt_n = cnt;
        if (state == IDLE && enc_vld) begin
            cnt_n = '0;
        end else if (state == GRANT) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // hold counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tp  <= 1'b0;
        end else begin
            cnt <= cnt_n;
            tp  <= tp_n;
        end
    end

    assign timeout_pulse = tp;
`else
    assign force_end = 1'b0;
`endif

    assign grant_end = (state == GRANT) &&
                       (rel || !req[gidx] || force_end);

    // next-state, grant and pointer update
    always_comb begin
        state_n = state;
        gidx_n  = gidx;
        oh_n    = oh;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (enc_vld) begin
                    state_n = GRANT;
                    gidx_n  = enc_idx;
                    oh_n    = W'(1) << enc_idx;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_n = IDLE;
                    oh_n    = '0;
                    ptr_n   = gidx + IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gidx  <= '0;
            oh    <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            gidx  <= gidx_n;
            oh    <= oh_n;
            ptr   <= ptr_n;
        end
    end

    assign grant_valid  = (state == GRANT);
    assign grant_idx    = gidx;
    assign grant_onehot = oh;
    assign rr_ptr       = ptr;

endmodule

// File: tb/tb_ppe_rr_arbiter.sv
// Self-checking bench for ppe_rr_arbiter at W=8 (MAX_HOLD=4 with timeout).
// Vector table drives the DUT; expected rows pass through a scoreboard queue.
module tb_ppe_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic [2:0] rr_ptr;
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic [2:0] ptr;
        logic       tp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    ppe_rr_arbiter #(
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
        .MAX_HOLD (4),
`endif
        .W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rel          (rel),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
        .timeout_pulse(timeout_pulse),
`endif
        .rr_ptr       (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [7:0] q,
                                input logic l, input logic v,
                                input int idx, input int ptr,
                                input logic tp = 1'b0);
        vec_t e;
        e.rst = r;
        e.req = q;
        e.rel = l;
        e.v   = v;
        e.idx = 3'(idx);
        e.oh  = v ? (8'd1 << idx) : 8'd0;
        e.ptr = 3'(ptr);
        e.tp  = tp;
        tbl.push_back(e);
    endfunction

    task automatic check(input int row, input string name,
                         input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL row %0d %s: got %0h expected %0h",
                     row, name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        req = '0;
        rel = 1'b0;

        // single request, release, re-grant
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h20, 0, 1, 5, 0);
        add(0, 8'h20, 0, 1, 5, 0);
        add(0, 8'h20, 0, 1, 5, 0);
        add(0, 8'h20, 1, 0, 5, 6);
        add(0, 8'h20, 0, 1, 5, 6);
        add(0, 8'h00, 0, 0, 5, 6);
        add(0, 8'h00, 0, 0, 5, 6);

        // round-robin order with all requesting
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'hFF, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 8'hFF, 1, 0, k, (k + 1) % 8);
            add(0, 8'hFF, 0, 1, (k + 1) % 8, (k + 1) % 8);
        end

        // wrap search
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h20, 0, 1, 5, 0);
        add(0, 8'h20, 1, 0, 5, 6);
        add(0, 8'h09, 0, 1, 0, 6);
        add(0, 8'h09, 1, 0, 0, 1);
        add(0, 8'h09, 0, 1, 3, 1);

        // withdrawal, then release during idle
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h04, 0, 1, 2, 0);
        add(0, 8'h00, 0, 0, 2, 3);
        add(0, 8'h00, 1, 0, 2, 3);
        add(0, 8'h00, 0, 0, 2, 3);

        // reset mid-grant
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h10, 0, 1, 4, 0);
        add(0, 8'h10, 1, 0, 4, 5);
        add(0, 8'h10, 0, 1, 4, 5);
        add(1, 8'hFF, 0, 0, 0, 0);
        add(0, 8'hFF, 0, 1, 0, 0);

`ifdef PPE_ARB_HOLD_TIMEOUT_EN
        // forced release after 4 grant cycles
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h02, 0, 1, 1, 0);
        add(0, 8'h02, 0, 1, 1, 0);
        add(0, 8'h02, 0, 1, 1, 0);
        add(0, 8'h02, 0, 1, 1, 0);
        add(0, 8'h02, 0, 0, 1, 2, 1'b1);
        add(0, 8'h02, 0, 1, 1, 2);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            req = tbl[i].req;
            rel = tbl[i].rel;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(i, "grant_valid", int'(grant_valid), int'(e.v));
            check(i, "grant_idx", int'(grant_idx), int'(e.idx));
            check(i, "grant_onehot", int'(grant_onehot), int'(e.oh));
            check(i, "rr_ptr", int'(rr_ptr), int'(e.ptr));
`ifdef PPE_ARB_HOLD_TIMEOUT_EN
            check(i, "timeout_pulse", int'(timeout_pulse), int'(e.tp));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
